// File: rtl/ysyx_25030093_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter.
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the arbiter.
// slave = arbiter view, master = environment (IFU/LSU/memory) view.
interface ysyx_25030093_mem_arbiter_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid;

  logic [31:0] resp_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_size, lsu_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid,
    output lsu_req_ready, lsu_resp_valid,
    output resp_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_size, lsu_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid,
    input  lsu_req_ready, lsu_resp_valid,
    input  resp_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata
  );

endinterface

// File: rtl/ysyx_25030093_arb_sel.sv
// Master selection: LSU-first priority with an anti-starvation counter
// that hands one contested arbitration to the IFU after STARVE_MAX
// consecutive contested LSU wins.
module ysyx_25030093_arb_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  output logic o_sel_ifu,
  output logic o_sel_lsu
);

  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

  logic [2:0] r_starve_cnt;
  logic       w_starved;
  logic       w_contested;

  assign w_starved   = (r_starve_cnt == LP_STARVE_MAX);
  assign w_contested = i_ifu_valid & i_lsu_valid;
  assign o_sel_lsu   = i_lsu_valid & ~(i_ifu_valid & w_starved);
  assign o_sel_ifu   = i_ifu_valid & ~o_sel_lsu;

  // Track contested LSU wins; in IDLE a contested cycle always handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if (i_idle && w_contested) begin
      if (o_sel_lsu) begin
        if (!w_starved) r_starve_cnt <= r_starve_cnt + 3'd1;
      end else begin
        r_starve_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU/LSU) to single-memory arbiter, one outstanding access.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready offered to the selected master; handshake latches request
// REQ     | mem_req_valid held with stable fields until mem_req_ready
// RESP    | waiting for mem_resp_valid; owner's resp_valid pulses with it
module ysyx_25030093_mem_arbiter
  import ysyx_25030093_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  ysyx_25030093_mem_arbiter_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  owner_e      r_owner;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;

  logic w_idle;
  logic w_sel_ifu;
  logic w_sel_lsu;
  logic w_ifu_ready;
  logic w_lsu_ready;
  logic w_hs_ifu;
  logic w_hs_lsu;
  logic w_ifu_resp;
  logic w_lsu_resp;

  assign w_idle = (r_state == ST_IDLE);

  ysyx_25030093_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_sel (
    .clk         (clk),
    .rst         (rst),
    .i_idle      (w_idle),
    .i_ifu_valid (bus.ifu_req_valid),
    .i_lsu_valid (bus.lsu_req_valid),
    .o_sel_ifu   (w_sel_ifu),
    .o_sel_lsu   (w_sel_lsu)
  );

  // Next state, ready/handshake and response pulses. Outputs are masked
  // while rst is high so an abandoned transaction never completes.
  always_comb begin
    w_state_nxt = r_state;
    w_ifu_ready = 1'b0;
    w_lsu_ready = 1'b0;
    w_hs_ifu    = 1'b0;
    w_hs_lsu    = 1'b0;
    w_ifu_resp  = 1'b0;
    w_lsu_resp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ifu_ready = ~rst & w_sel_ifu;
        w_lsu_ready = ~rst & w_sel_lsu;
        w_hs_ifu    = w_ifu_ready & bus.ifu_req_valid;
        w_hs_lsu    = w_lsu_ready & bus.lsu_req_valid;
        if (w_hs_ifu || w_hs_lsu) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.mem_req_ready) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt = ST_IDLE;
          w_ifu_resp  = ~rst & (r_owner == OWN_IFU);
          w_lsu_resp  = ~rst & (r_owner == OWN_LSU);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus owner/request capture on the IDLE handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IFU;
      r_addr  <= 32'd0;
      r_wen   <= 1'b0;
      r_size  <= 2'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs_ifu) begin
        r_owner <= OWN_IFU;
        r_addr  <= bus.ifu_addr;
        r_wen   <= 1'b0;
        r_size  <= SZ_W;
        r_wdata <= 32'd0;
      end else if (w_hs_lsu) begin
        r_owner <= OWN_LSU;
        r_addr  <= bus.lsu_addr;
        r_wen   <= bus.lsu_wen;
        r_size  <= bus.lsu_size;
        r_wdata <= bus.lsu_wdata;
      end
    end
  end

  assign bus.ifu_req_ready  = w_ifu_ready;
  assign bus.lsu_req_ready  = w_lsu_ready;
  assign bus.ifu_resp_valid = w_ifu_resp;
  assign bus.lsu_resp_valid = w_lsu_resp;
  assign bus.resp_rdata     = bus.mem_rdata;
  assign bus.mem_req_valid  = (r_state == ST_REQ);
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wen        = r_wen;
  assign bus.mem_size       = r_size;
  assign bus.mem_wdata      = r_wdata;

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios plus random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_ysyx_25030093_mem_arbiter;
  import ysyx_25030093_pkg::*;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25030093_mem_arbiter_if bus();

  ysyx_25030093_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one outstanding transaction (busy/accepted) plus the
  // number of consecutive contested LSU wins.
  bit          m_busy, m_acc, m_own_lsu, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  int          m_streak;

  bit    ob_gi, ob_gl, ob_ri, ob_rl;
  int    n_resp_ifu, n_resp_lsu;
  string grants;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input bit iv, input logic [31:0] ia,
                      input bit lv, input logic [31:0] la, input bit lw,
                      input logic [1:0] ls, input logic [31:0] lwd,
                      input bit mrdy, input bit mrv, input logic [31:0] mrd);
    bit e_gi, e_gl, e_ri, e_rl;
    bus.ifu_req_valid  = iv;
    bus.ifu_addr       = ia;
    bus.lsu_req_valid  = lv;
    bus.lsu_addr       = la;
    bus.lsu_wen        = lw;
    bus.lsu_size       = ls;
    bus.lsu_wdata      = lwd;
    bus.mem_req_ready  = mrdy;
    bus.mem_resp_valid = mrv;
    bus.mem_rdata      = mrd;
    @(negedge clk);
    e_gi = 1'b0; e_gl = 1'b0; e_ri = 1'b0; e_rl = 1'b0;
    if (!m_busy) begin
      e_gl = lv && (!iv || m_streak != STARVE_MAX);
      e_gi = iv && !e_gl;
    end else if (m_acc) begin
      e_ri = mrv && !m_own_lsu;
      e_rl = mrv && m_own_lsu;
    end
    chk("rdy_ifu",  32'(bus.ifu_req_ready),  32'(e_gi));
    chk("rdy_lsu",  32'(bus.lsu_req_ready),  32'(e_gl));
    chk("resp_ifu", 32'(bus.ifu_resp_valid), 32'(e_ri));
    chk("resp_lsu", 32'(bus.lsu_resp_valid), 32'(e_rl));
    chk("mem_vld",  32'(bus.mem_req_valid),  32'(m_busy && !m_acc));
    chk("rdata",    bus.resp_rdata, mrd);
    if (m_busy && !m_acc) begin
      chk("mem_addr",  bus.mem_addr, m_addr);
      chk("mem_ctl",   32'({bus.mem_wen, bus.mem_size}), 32'({m_wen, m_size}));
      chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    ob_gi = bus.ifu_req_ready & iv;
    ob_gl = bus.lsu_req_ready & lv;
    ob_ri = bus.ifu_resp_valid;
    ob_rl = bus.lsu_resp_valid;
    if (ob_gi) grants = {grants, "I"};
    if (ob_gl) grants = {grants, "L"};
    if (ob_ri) n_resp_ifu++;
    if (ob_rl) n_resp_lsu++;
    @(posedge clk);
    if (!m_busy) begin
      if (iv && lv) m_streak = e_gl ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
      if (e_gi) begin
        m_busy = 1; m_acc = 0; m_own_lsu = 0;
        m_addr = ia; m_wen = 0; m_size = SZ_W; m_wdata = 32'd0;
      end else if (e_gl) begin
        m_busy = 1; m_acc = 0; m_own_lsu = 1;
        m_addr = la; m_wen = lw; m_size = ls; m_wdata = lwd;
      end
    end else if (!m_acc) begin
      if (mrdy) m_acc = 1;
    end else if (mrv) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic idle(input bit mrdy, input bit mrv);
    step(0, 32'd0, 0, 32'd0, 0, 2'd0, 32'd0, mrdy, mrv, $urandom);
  endtask

  task automatic ifu(input logic [31:0] a, input bit mrdy, input bit mrv);
    step(1, a, 0, 32'd0, 0, 2'd0, 32'd0, mrdy, mrv, $urandom);
  endtask

  task automatic do_reset(input int n, input bit mrv);
    rst = 1'b1;
    bus.ifu_req_valid  = 0;
    bus.lsu_req_valid  = 0;
    bus.mem_req_ready  = 0;
    bus.mem_resp_valid = mrv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_resp_ifu", 32'(bus.ifu_resp_valid), 32'd0);
      chk("rst_resp_lsu", 32'(bus.lsu_resp_valid), 32'd0);
      if (i > 0) begin
        chk("rst_mem_vld",   32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_addr",  bus.mem_addr, 32'd0);
        chk("rst_mem_ctl",   32'({bus.mem_wen, bus.mem_size}), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m_busy = 0; m_acc = 0; m_streak = 0;
  endtask

  initial begin
    string exp_s;
    int    base;
    bus.ifu_req_valid = 0; bus.ifu_addr = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0;
    bus.lsu_size = 0; bus.lsu_wdata = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;
    m_busy = 0; m_acc = 0; m_streak = 0;
    @(posedge clk); #1;
    do_reset(2, 0);

    // Single IFU fetch, minimum latency.
    n_resp_lsu = 0;
    ifu(32'h8000_0000, 1, 0);
    chk("fetch_hs", 32'(ob_gi), 32'd1);
    idle(1, 0);
    chk("fetch_c1_resp", 32'(ob_ri), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0413);
    chk("fetch_c2_resp", 32'(ob_ri), 32'd1);
    chk("fetch_lsu_quiet", 32'(n_resp_lsu), 32'd0);
    idle(0, 0);

    // LSU byte store with three memory wait cycles.
    n_resp_lsu = 0;
    step(0, 0, 1, 32'h8000_1003, 1, SZ_B, 32'h0000_00AB, 0, 0, 0);
    repeat (3) idle(0, 1);
    chk("sb_addr", bus.mem_addr, 32'h8000_1003);
    chk("sb_wen",  32'(bus.mem_wen), 32'd1);
    chk("sb_size", 32'(bus.mem_size), 32'(SZ_B));
    chk("sb_wdata", bus.mem_wdata, 32'h0000_00AB);
    idle(1, 0);
    idle(0, 1);
    repeat (3) idle(0, 1);
    chk("sb_pulses", 32'(n_resp_lsu), 32'd1);

    // Stray memory responses in IDLE and REQ are ignored.
    n_resp_ifu = 0;
    idle(0, 1);
    ifu(32'h8000_0010, 0, 1);
    idle(0, 1);
    idle(0, 1);
    chk("stray_resp", 32'(n_resp_ifu), 32'd0);
    idle(1, 0);
    idle(0, 1);
    chk("stray_then_real", 32'(n_resp_ifu), 32'd1);

    // Reset while waiting in RESP abandons the transaction.
    ifu(32'h8000_0020, 0, 0);
    idle(1, 0);
    n_resp_ifu = 0; n_resp_lsu = 0;
    do_reset(2, 1);
    idle(0, 1);
    chk("rst_abandon", 32'(n_resp_ifu + n_resp_lsu), 32'd0);
    ifu(32'h8000_0024, 1, 0);
    chk("post_rst_accept", 32'(ob_gi), 32'd1);
    idle(1, 1);

    // Continuous contention, zero-wait memory.
    do_reset(2, 0);
    grants = "";
    repeat (30) step(1, $urandom, 1, $urandom, 1'($urandom), 2'($urandom_range(0, 3)),
                     $urandom, 1, 1, $urandom);
    exp_s = "LLLLILLLLI";
    chk("order_len", 32'(grants.len()), 32'd10);
    for (int i = 0; i < 10 && i < grants.len(); i++)
      chk("grant_order", 32'(grants[i]), 32'(exp_s[i]));

    // IFU-only traffic must not count toward starvation.
    do_reset(2, 0);
    grants = "";
    repeat (30) ifu($urandom, 1, 1);
    chk("ifu_only_cnt", 32'(grants.len()), 32'd10);
    grants = "";
    repeat (15) step(1, $urandom, 1, $urandom, 0, SZ_W, $urandom, 1, 1, $urandom);
    exp_s = "LLLLI";
    chk("contend_len", 32'(grants.len()), 32'd5);
    for (int i = 0; i < 5 && i < grants.len(); i++)
      chk("contend_order", 32'(grants[i]), 32'(exp_s[i]));

    // Random traffic against the model.
    do_reset(2, 0);
    base = n_resp_ifu + n_resp_lsu;
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 99) < 65), $urandom, 1'($urandom),
           2'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), $urandom);
    end
    if (n_resp_ifu + n_resp_lsu == base)
      chk("random_progress", 32'(n_resp_ifu + n_resp_lsu - base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_mem_arbiter.md
YSYX_25030093_MEM_ARBITER -- requirements
Module: ysyx_25030093_mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive contested LSU wins after which the next contested arbitration goes to the IFU.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ifu_req_valid  in  1  IFU fetch request; the IFU only reads, 4 bytes.
REQ-006 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 ifu_addr  in  32  IFU fetch address.
REQ-008 ifu_resp_valid  out  1  IFU response pulse; resp_rdata is valid in this cycle.
REQ-009 lsu_req_valid  in  1  LSU load/store request.
REQ-010 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-011 lsu_addr  in  32  LSU byte address.
REQ-012 lsu_wen  in  1  1 = store, 0 = load.
REQ-013 lsu_size  in  2  encoding: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is reserved and is forwarded unchanged.
REQ-014 lsu_wdata  in  32  store data, right-aligned.
REQ-015 lsu_resp_valid  out  1  LSU response pulse: load data or store acknowledge.
REQ-016 resp_rdata  out  32  response data shared by both masters; it is a direct copy of mem_rdata.
REQ-017 mem_req_valid  out  1  memory request valid.
REQ-018 mem_req_ready  in  1  memory accepts the request.
REQ-019 mem_addr / mem_wen / mem_size / mem_wdata  out  32/1/2/32  registered request fields.
REQ-020 mem_resp_valid  in  1  memory response, one cycle.
REQ-021 mem_rdata  in  32  memory read data.

Function
REQ-022 The FSM SHALL have three states: IDLE, REQ and RESP; reset enters IDLE.
REQ-023 IDLE SHALL drive ready combinationally to exactly one master, the selected one; a handshake is valid && ready.
REQ-024 Selection rules:
- If only one master is valid, that master is selected.
- If both are valid, the LSU is selected unless starve_cnt == STARVE_MAX, in which case the IFU is selected.
REQ-025 starve_cnt SHALL be 3 bits and SHALL be updated only on contested handshakes:
- contested LSU win: increment, saturating at STARVE_MAX;
- contested IFU win: clear to 0;
- uncontested handshake: no change.
REQ-026 On a handshake the FSM SHALL latch the owner and the request fields and enter REQ. IFU requests are forced to wen = 0, size = 2 and wdata = 0.
REQ-027 In REQ the block SHALL hold mem_req_valid = 1 with stable fields until mem_req_ready; on mem_req_ready it enters RESP.
REQ-028 In RESP the block SHALL wait for mem_resp_valid, then:
- pulse the owner's resp_valid combinationally in that same cycle;
- return to IDLE on the next edge.
REQ-029 Both ready outputs SHALL be 0 in REQ and RESP; at most one transaction is outstanding.
REQ-030 mem_resp_valid outside RESP SHALL be ignored, producing no response pulse.
REQ-031 Minimum latency from handshake (cycle 0) to response is cycle 2, reached when mem_req_ready = 1 in cycle 1 and mem_resp_valid = 1 in cycle 2.
REQ-032 A store SHALL also wait for mem_resp_valid, which acts as its acknowledge.
REQ-033 The return to IDLE and the next arbitration SHALL occur on the edge after the response cycle, giving one idle cycle between transactions.

Reset
REQ-034 Reset SHALL set state = IDLE, starve_cnt = 0, mem_req_valid = 0, mem_addr/mem_wen/mem_size/mem_wdata = 0, and owner = IFU.
REQ-035 Reset during REQ or RESP SHALL abandon the transaction: no response pulse is issued, and the block accepts a new request in the first cycle after reset deasserts.

Structure
REQ-036 The state encoding, owner encoding and size encoding (SZ_B = 0, SZ_H = 1, SZ_W = 2) SHALL live in the shared package ysyx_25030093_pkg.
REQ-037 The priority/starvation selection logic SHALL be one sub-module, ysyx_25030093_arb_sel; the FSM and the request registers stay in the top module.

Verification
REQ-038 Single IFU read, addr 0x80000000, with mem_req_ready = 1 and a one-cycle mem response carrying 0x00000413 -> ifu_resp_valid in cycle 2, resp_rdata = 0x00000413, lsu_resp_valid stays 0.
REQ-039 Both masters valid continuously, memory with zero wait -> grant order L, L, L, L, I, L, L, L, L, I, with STARVE_MAX = 4.
REQ-040 LSU sb: addr 0x80001003, wdata 0x000000AB, mem_req_ready held 0 for 3 cycles -> mem fields stable throughout with mem_wen = 1 and mem_size = 0; lsu_resp_valid is pulsed exactly once.
REQ-041 mem_resp_valid = 1 while in IDLE or REQ -> no resp_valid pulse on either master.
REQ-042 rst asserted in RESP, then mem_resp_valid -> no response pulse; state returns to IDLE and mem_req_valid = 0.
REQ-043 IFU valid alone for 10 transactions, then contention -> starve_cnt stays 0 through the IFU-only transactions and the first contested grant goes to the LSU.
